// File: rtl/multicycle_seq.sv
// multicycle_seq: multi-cycle instruction sequencer for the MIPS datapath.
// Each instruction steps through FETCH/DECODE/EXEC/MEM/WB. The block issues
// one-cycle strobes to the IR, ALU, data memory, register file and PC.
//
// Ports
//   clk, rst_n          clock (rising edge) and asynchronous active-low reset
//   start               leaves IDLE/HALT and begins fetching
//   opcode              IR opcode field, sampled in DECODE
//   dec_*               decoded class bits, latched in DECODE
//   imem_ack, dmem_ack  memory handshakes (ignored outside FETCH/MEM)
//   imem_req, ir_load, alu_en, dmem_req, dmem_we, rf_we, pc_write, pc_sel
//                       datapath strobes (combinational from state/latched bits/acks)
//   halted, error       sequencer is in HALT / ERR
//   state               current state encoding
//   retired             retired-instruction count (wraps)
module multicycle_seq #(
   parameter logic [8:0] HALT_OP = 9'h1FF,
   parameter int         TIMEOUT = 16,
   parameter int         CNT_W   = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [8:0]       opcode,
   input  logic             dec_mem_read,
   input  logic             dec_mem_write,
   input  logic             dec_reg_write,
   input  logic [1:0]       dec_pc_src,
   input  logic             imem_ack,
   input  logic             dmem_ack,
   output logic             imem_req,
   output logic             ir_load,
   output logic             alu_en,
   output logic             dmem_req,
   output logic             dmem_we,
   output logic             rf_we,
   output logic             pc_write,
   output logic [1:0]       pc_sel,
   output logic             halted,
   output logic             error,
   output logic [2:0]       state,
   output logic [CNT_W-1:0] retired
);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_FETCH  = 3'd1,
      S_DECODE = 3'd2,
      S_EXEC   = 3'd3,
      S_MEM    = 3'd4,
      S_WB     = 3'd5,
      S_HALT   = 3'd6,
      S_ERR    = 3'd7
   } state_e;

   localparam int WAIT_W = $clog2(TIMEOUT + 1);

   state_e             state_q, state_d;
   logic [WAIT_W-1:0]  wait_q, wait_d;
   logic               rd_q, rd_d, wr_q, wr_d, rw_q, rw_d;
   logic [1:0]         pcs_q, pcs_d;
   logic [CNT_W-1:0]   retired_q, retired_d;
   logic               wait_expired;

   // Strobes
   always_comb begin
      imem_req = (state_q == S_FETCH);
      ir_load  = (state_q == S_FETCH) & imem_ack;
      alu_en   = (state_q == S_EXEC);
      dmem_req = (state_q == S_MEM);
      dmem_we  = (state_q == S_MEM) & wr_q;
      rf_we    = (state_q == S_WB);
      // Retire points: EXEC with no mem/writeback, MEM completion without
      // load writeback, and WB.
      pc_write = ((state_q == S_EXEC) & ~(rd_q | wr_q) & ~rw_q) |
                 ((state_q == S_MEM) & dmem_ack & ~(rd_q & rw_q)) |
                 (state_q == S_WB);
      pc_sel   = pc_write ? pcs_q : 2'b00;
      halted   = (state_q == S_HALT);
      error    = (state_q == S_ERR);
   end

   assign state   = state_q;
   assign retired = retired_q;

   // The cycle that would make the TIMEOUT-th consecutive un-acked cycle.
   assign wait_expired = (wait_q == WAIT_W'(TIMEOUT - 1));

   // Next state
   always_comb begin
      state_d   = state_q;
      wait_d    = '0;
      rd_d      = rd_q;
      wr_d      = wr_q;
      rw_d      = rw_q;
      pcs_d     = pcs_q;
      retired_d = pc_write ? retired_q + CNT_W'(1) : retired_q;
      case (state_q)
         S_IDLE: if (start) state_d = S_FETCH;
         S_FETCH: begin
            if (imem_ack)          state_d = S_DECODE;
            else if (wait_expired) state_d = S_ERR;
            else                   wait_d  = wait_q + WAIT_W'(1);
         end
         S_DECODE: begin
            rd_d  = dec_mem_read;
            wr_d  = dec_mem_write;
            rw_d  = dec_reg_write;
            pcs_d = dec_pc_src;
            if (opcode == HALT_OP)                 state_d = S_HALT;
            else if (dec_mem_read & dec_mem_write) state_d = S_ERR;
            else                                   state_d = S_EXEC;
         end
         S_EXEC: begin
            if (rd_q | wr_q) state_d = S_MEM;
            else if (rw_q)   state_d = S_WB;
            else             state_d = S_FETCH;
         end
         S_MEM: begin
            if (dmem_ack)          state_d = (rd_q & rw_q) ? S_WB : S_FETCH;
            else if (wait_expired) state_d = S_ERR;
            else                   wait_d  = wait_q + WAIT_W'(1);
         end
         S_WB:    state_d = S_FETCH;
         S_HALT:  if (start) state_d = S_FETCH;
         default: state_d = S_ERR;   // ERR is left only through reset
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= S_IDLE;
         wait_q    <= '0;
         rd_q      <= 1'b0;
         wr_q      <= 1'b0;
         rw_q      <= 1'b0;
         pcs_q     <= 2'b00;
         retired_q <= '0;
      end else begin
         state_q   <= state_d;
         wait_q    <= wait_d;
         rd_q      <= rd_d;
         wr_q      <= wr_d;
         rw_q      <= rw_d;
         pcs_q     <= pcs_d;
         retired_q <= retired_d;
      end
   end

endmodule

// File: tb/tb_multicycle_seq.sv
// Directed bench for multicycle_seq. The stimulus process drives inputs
// for one cycle and queues the hand-computed outputs expected in that cycle.
// A monitor pops and compares on every falling edge.
module tb_multicycle_seq;

   typedef struct packed {
      logic [2:0]  st;
      logic [6:0]  str;  // imem_req ir_load alu_en dmem_req dmem_we rf_we pc_write
      logic [1:0]  ps;
      logic [1:0]  he;   // halted error
      logic [15:0] ret;
   } exp_t;

   localparam logic [6:0] IR = 7'b1000000, IL = 7'b0100000, AE = 7'b0010000,
                          DR = 7'b0001000, DW = 7'b0000100, RF = 7'b0000010,
                          PW = 7'b0000001, NO = 7'b0000000;

   logic        clk = 1'b0, rst_n = 1'b0, start = 1'b0;
   logic [8:0]  opcode = 9'h0;
   logic        rd = 1'b0, wr = 1'b0, rw = 1'b0, iack = 1'b0, dack = 1'b0;
   logic [1:0]  pcsrc = 2'b00;
   logic        imem_req, ir_load, alu_en, dmem_req, dmem_we, rf_we, pc_write;
   logic        halted, error;
   logic [1:0]  pc_sel;
   logic [2:0]  state;
   logic [15:0] retired;

   int total = 0, bad = 0;
   exp_t q[$];

   always #5 clk = ~clk;

   multicycle_seq dut (
      .clk(clk), .rst_n(rst_n), .start(start), .opcode(opcode),
      .dec_mem_read(rd), .dec_mem_write(wr), .dec_reg_write(rw),
      .dec_pc_src(pcsrc), .imem_ack(iack), .dmem_ack(dack),
      .imem_req(imem_req), .ir_load(ir_load), .alu_en(alu_en),
      .dmem_req(dmem_req), .dmem_we(dmem_we), .rf_we(rf_we),
      .pc_write(pc_write), .pc_sel(pc_sel), .halted(halted), .error(error),
      .state(state), .retired(retired)
   );

   function automatic exp_t ex(input logic [2:0] st, input logic [6:0] s,
                               input logic [1:0] ps, input logic [1:0] he,
                               input logic [15:0] ret);
      ex = '{st: st, str: s, ps: ps, he: he, ret: ret};
   endfunction

   // Queue the expected outputs for the current cycle, then advance one cycle.
   task automatic tick(input exp_t e);
      q.push_back(e);
      @(posedge clk);
      #1;
   endtask

   // Monitor
   always @(negedge clk) begin
      if (q.size() > 0) begin
         exp_t e, a;
         e = q.pop_front();
         a = '{st: state,
               str: {imem_req, ir_load, alu_en, dmem_req, dmem_we, rf_we, pc_write},
               ps: pc_sel, he: {halted, error}, ret: retired};
         total++;
         if (a !== e) begin
            bad++;
            $display("FAIL cycle%0d t=%0t: got st=%0d str=%b ps=%b he=%b ret=%0d, want st=%0d str=%b ps=%b he=%b ret=%0d",
                     total, $time, a.st, a.str, a.ps, a.he, a.ret,
                     e.st, e.str, e.ps, e.he, e.ret);
         end
      end
   end

   initial begin
      @(posedge clk); #1;
      // Reset
      tick(ex(0, NO, 0, 0, 0));
      tick(ex(0, NO, 0, 0, 0));
      rst_n = 1'b1;
      tick(ex(0, NO, 0, 0, 0));                          // idle, no start

      // ALU reg-write: F D E W; dmem_ack in FETCH is ignored
      start = 1; tick(ex(0, NO, 0, 0, 0));
      start = 0; iack = 1; dack = 1; tick(ex(1, IR|IL, 0, 0, 0));
      iack = 0; dack = 0; opcode = 9'h020; rw = 1; tick(ex(2, NO, 0, 0, 0));
      rw = 0; tick(ex(3, AE, 0, 0, 0));                  // latched rw still 1
      tick(ex(5, RF|PW, 0, 0, 0));

      // Load, dmem_ack after 3 wait cycles: 8 cycles total
      iack = 1; tick(ex(1, IR|IL, 0, 0, 1));
      iack = 0; rd = 1; rw = 1; tick(ex(2, NO, 0, 0, 1));
      rd = 0; rw = 0; tick(ex(3, AE, 0, 0, 1));
      for (int i = 0; i < 3; i++) tick(ex(4, DR, 0, 0, 1));
      dack = 1; tick(ex(4, DR, 0, 0, 1));
      dack = 0; tick(ex(5, RF|PW, 0, 0, 1));

      // Store; decode inputs flipped during EXEC/MEM must be ignored
      iack = 1; tick(ex(1, IR|IL, 0, 0, 2));
      iack = 0; wr = 1; tick(ex(2, NO, 0, 0, 2));
      wr = 0; rd = 1; rw = 1; pcsrc = 2'b11; tick(ex(3, AE, 0, 0, 2));
      dack = 1; tick(ex(4, DR|DW|PW, 0, 0, 2));
      dack = 0; rd = 0; rw = 0; pcsrc = 2'b00;

      // Branch: retires from EXEC with pc_sel=01
      iack = 1; tick(ex(1, IR|IL, 0, 0, 3));
      iack = 0; pcsrc = 2'b01; tick(ex(2, NO, 0, 0, 3));
      pcsrc = 2'b00; tick(ex(3, AE|PW, 2'b01, 0, 3));

      // HALT: no retire, start resumes fetching with count held
      iack = 1; tick(ex(1, IR|IL, 0, 0, 4));
      iack = 0; opcode = 9'h1FF; rw = 1; tick(ex(2, NO, 0, 0, 4));
      opcode = 9'h000; rw = 0; tick(ex(6, NO, 0, 2'b10, 4));
      tick(ex(6, NO, 0, 2'b10, 4));
      start = 1; tick(ex(6, NO, 0, 2'b10, 4));
      start = 0;

      // Boundary: ack on the 16th request cycle still wins
      for (int i = 0; i < 15; i++) tick(ex(1, IR, 0, 0, 4));
      iack = 1; tick(ex(1, IR|IL, 0, 0, 4));
      iack = 0; pcsrc = 2'b10; tick(ex(2, NO, 0, 0, 4));
      tick(ex(3, AE|PW, 2'b10, 0, 4));
      pcsrc = 2'b00;

      // Timeout: 16 cycles without imem_ack -> ERR; start ignored
      for (int i = 0; i < 16; i++) tick(ex(1, IR, 0, 0, 5));
      start = 1; tick(ex(7, NO, 0, 2'b01, 5));
      tick(ex(7, NO, 0, 2'b01, 5));
      start = 0; tick(ex(7, NO, 0, 2'b01, 5));

      // Reset leaves ERR and clears the count
      rst_n = 0; tick(ex(0, NO, 0, 0, 0));
      rst_n = 1;

      // Illegal decode rd=wr=1 -> ERR
      start = 1; tick(ex(0, NO, 0, 0, 0));
      start = 0; iack = 1; tick(ex(1, IR|IL, 0, 0, 0));
      iack = 0; rd = 1; wr = 1; tick(ex(2, NO, 0, 0, 0));
      rd = 0; wr = 0; tick(ex(7, NO, 0, 2'b01, 0));

      // Reset asserted mid-instruction aborts with no strobe
      rst_n = 0; tick(ex(0, NO, 0, 0, 0));
      rst_n = 1; start = 1; tick(ex(0, NO, 0, 0, 0));
      start = 0; iack = 1; tick(ex(1, IR|IL, 0, 0, 0));
      iack = 0; rw = 1; tick(ex(2, NO, 0, 0, 0));
      rst_n = 0; tick(ex(0, NO, 0, 0, 0));                // was about to EXEC
      rst_n = 1; rw = 0; tick(ex(0, NO, 0, 0, 0));

      // Drain bound
      for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge clk);
      if (q.size() > 0) begin
         total++; bad++;
         $display("FAIL drain: got %0d pending entries, want 0", q.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
